reg_bank_sched: RTL and testbench

REG_BANK_SCHED -- requirements
Module: reg_bank_sched

---
 rtl/reg_bank_sched_if.sv | 26 ++
 rtl/reg_bank_sched.sv | 114 +++++++++++
 tb/tb_reg_bank_sched.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_sched_if.sv
// Requester/register-bank bundle for reg_bank_sched: master = requesters and bank, slave = scheduler.
interface reg_bank_sched_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) ();
  logic [2:0]          req;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*DATA_W-1:0] req_data;
  logic [2:0]          gnt;
  logic [2:0]          ack;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                busy;
  logic [7:0]          wr_cnt;

  modport master (
    output req, req_addr, req_data,
    input  gnt, ack, wr_en, wr_addr, wr_data, busy, wr_cnt
  );

  modport slave (
    input  req, req_addr, req_data,
    output gnt, ack, wr_en, wr_addr, wr_data, busy, wr_cnt
  );
endinterface

// File: rtl/reg_bank_sched.sv
// Three-requester register-bank write scheduler; grant N+1, wr_en N+2, ack N+3, >=5 cycles per write.
// Requesters hold req until released; winner holds gnt until it drops req. REG_BANK_SCHED_FIXED_PRIO_EN selects fixed priority.
module reg_bank_sched #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input logic            clk,
  input logic            rst,
  reg_bank_sched_if.slave bus
);

  typedef enum logic [2:0] {IDLE, GRANT, WRITE, ACK, RELEASE} state_t;

  state_t            state;
  logic [1:0]        win;
  logic [1:0]        pick_w;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

`ifdef REG_BANK_SCHED_FIXED_PRIO_EN
  function automatic logic [1:0] pick(input logic [2:0] r);
    logic [1:0] res;
    res = 2'd2;
    if (r[1]) res = 2'd1;
    if (r[0]) res = 2'd0;
    return res;
  endfunction

  assign pick_w = pick(bus.req);
`else
  logic [1:0] ptr;

  // Scan downward so the first set bit at or after p (mod 3) is the last one kept.
  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] res;
    int         idx;
    res = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= 3) idx = idx - 3;
      if (r[idx]) res = 2'(idx);
    end
    return res;
  endfunction

  assign pick_w = pick(bus.req, ptr);
`endif

  assign sel_addr = bus.req_addr[ADDR_W*pick_w +: ADDR_W];
  assign sel_data = bus.req_data[DATA_W*pick_w +: DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      win         <= 2'd0;
      bus.gnt     <= 3'b000;
      bus.ack     <= 3'b000;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.busy    <= 1'b0;
      bus.wr_cnt  <= 8'd0;
`ifndef REG_BANK_SCHED_FIXED_PRIO_EN
      ptr         <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            win         <= pick_w;
            bus.gnt     <= 3'b001 << pick_w;
            bus.wr_addr <= sel_addr;
            bus.wr_data <= sel_data;
            bus.busy    <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (bus.req[win]) begin
            bus.wr_en <= 1'b1;
            state     <= WRITE;
          end else begin
            // Requester withdrew before the write: abort without touching the pointer.
            bus.gnt  <= 3'b000;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        WRITE: begin
          bus.wr_en  <= 1'b0;
          bus.ack    <= bus.gnt;
          bus.wr_cnt <= bus.wr_cnt + 8'd1;
`ifndef REG_BANK_SCHED_FIXED_PRIO_EN
          ptr        <= (win == 2'd2) ? 2'd0 : win + 2'd1;
`endif
          state      <= ACK;
        end
        ACK: begin
          bus.ack <= 3'b000;
          state   <= RELEASE;
        end
        RELEASE: begin
          if (!bus.req[win]) begin
            bus.gnt  <= 3'b000;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_sched.sv
// Directed plus randomized bench for reg_bank_sched against a transaction-level arbitration model.
module tb_reg_bank_sched;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   ptr_m;
  int   cnt_m;
  logic [2:0] obs;
  logic [2:0] order_exp [4];

  reg_bank_sched_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  reg_bank_sched #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [2:0] oh(input int w);
    logic [2:0] one;
    one = 3'b001;
    return one << w;
  endfunction

  function automatic int model_pick(input logic [2:0] r);
`ifdef REG_BANK_SCHED_FIXED_PRIO_EN
    for (int k = 0; k < 3; k++) if (r[k]) return k;
`else
    for (int k = 0; k < 3; k++) if (r[(ptr_m + k) % 3]) return (ptr_m + k) % 3;
`endif
    return 0;
  endfunction

  // Called right after a falling edge with the scheduler idle; returns right after a falling edge, idle again.
  task automatic txn(input logic [2:0] mask, input logic [11:0] addrs, input logic [23:0] datas,
                     input bit abort, input int hold, output logic [2:0] gnt_seen);
    int         w;
    logic [3:0] a;
    logic [7:0] d;
    w = model_pick(mask);
    a = addrs[4*w +: 4];
    d = datas[8*w +: 8];
    bus.req_addr = addrs;
    bus.req_data = datas;
    bus.req      = mask;
    @(negedge clk);
    gnt_seen = bus.gnt;
    chk("gnt_at_n1", bus.gnt, oh(w));
    chk("busy_at_n1", bus.busy, 1);
    chk("wr_en_at_n1", bus.wr_en, 0);
    bus.req_addr = 12'($urandom);
    bus.req_data = 24'($urandom);
    if (abort) bus.req = 3'b000;
    @(negedge clk);
    if (abort) begin
      chk("abort_gnt", bus.gnt, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_wr_en", bus.wr_en, 0);
      chk("abort_ack", bus.ack, 0);
      chk("abort_cnt", bus.wr_cnt, cnt_m);
      return;
    end
    chk("wr_en_at_n2", bus.wr_en, 1);
    chk("wr_addr", bus.wr_addr, a);
    chk("wr_data", bus.wr_data, d);
    chk("ack_at_n2", bus.ack, 0);
    @(negedge clk);
    cnt_m = (cnt_m + 1) % 256;
    ptr_m = (w + 1) % 3;
    chk("wr_en_at_n3", bus.wr_en, 0);
    chk("ack_at_n3", bus.ack, oh(w));
    chk("wr_cnt", bus.wr_cnt, cnt_m);
    @(negedge clk);
    chk("ack_cleared", bus.ack, 0);
    chk("gnt_release", bus.gnt, oh(w));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("gnt_held", bus.gnt, oh(w));
      chk("busy_held", bus.busy, 1);
    end
    bus.req = bus.req & ~oh(w);
    @(negedge clk);
    chk("gnt_dropped", bus.gnt, 0);
    chk("busy_idle", bus.busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 3'b000;
    ptr_m = 0;
    cnt_m = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] m;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.req      = 3'b000;
    bus.req_addr = 12'h000;
    bus.req_data = 24'h000000;
    ptr_m = 0;
    cnt_m = 0;

    // Reset state
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wr_cnt", bus.wr_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_req_gnt", bus.gnt, 0);

    // Single write from requester 1
    txn(3'b010, 12'h050, 24'h00A700, 1'b0, 0, obs);
    chk("single_gnt", obs, 3'b010);
    chk("single_cnt", bus.wr_cnt, 1);

    // Contention: all three hold, winner drops after ack and re-asserts
    do_reset();
`ifdef REG_BANK_SCHED_FIXED_PRIO_EN
    order_exp = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
    order_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
    for (int i = 0; i < 4; i++) begin
      txn(3'b111, 12'($urandom), 24'($urandom), 1'b0, i % 2, obs);
      chk("contention_order", obs, order_exp[i]);
    end

    // Abort after reset, then the next search still starts at requester 0
    do_reset();
    txn(3'b100, 12'($urandom), 24'($urandom), 1'b1, 0, obs);
    @(negedge clk);
    chk("abort_no_wr_en", bus.wr_en, 0);
    txn(3'b111, 12'($urandom), 24'($urandom), 1'b0, 0, obs);
    chk("after_abort_gnt", obs, 3'b001);

    // Data change during GRANT is ignored
    txn(3'b001, 12'h003, 24'h000011, 1'b0, 0, obs);
    chk("data_change_cnt", bus.wr_cnt, cnt_m);

    // Reset pulse during GRANT, with a nonzero pointer beforehand
    txn(3'b001, 12'($urandom), 24'($urandom), 1'b0, 0, obs);
    bus.req = 3'b110;
    @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_gnt", bus.gnt, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_cnt", bus.wr_cnt, 0);
    chk("mid_rst_wr_addr", bus.wr_addr, 0);
    chk("mid_rst_wr_data", bus.wr_data, 0);
    #1 rst = 1'b0;
    bus.req = 3'b000;
    ptr_m = 0;
    cnt_m = 0;
    @(negedge clk);
    chk("post_rst_wr_en", bus.wr_en, 0);
    chk("post_rst_gnt", bus.gnt, 0);
    txn(3'b111, 12'($urandom), 24'($urandom), 1'b0, 0, obs);
    chk("post_rst_ptr0", obs, 3'b001);

    // Reset during WRITE drops wr_en immediately
    bus.req = 3'b010;
    @(negedge clk);
    @(negedge clk);
    chk("write_cycle_wr_en", bus.wr_en, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_in_write_wr_en", bus.wr_en, 0);
    chk("rst_in_write_cnt", bus.wr_cnt, 0);
    #1 rst = 1'b0;
    bus.req = 3'b000;
    ptr_m = 0;
    cnt_m = 0;
    @(negedge clk);
    chk("rst_in_write_no_ack", bus.ack, 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      m = 3'($urandom_range(1, 7));
      txn(m, 12'($urandom), 24'($urandom), ($urandom_range(0, 4) == 0), $urandom_range(0, 2), obs);
    end
    bus.req = 3'b000;

    // Counter wrap after 256 writes
    do_reset();
    for (int i = 0; i < 256; i++) begin
      m = 3'($urandom_range(1, 7));
      txn(m, 12'($urandom), 24'($urandom), 1'b0, 0, obs);
    end
    bus.req = 3'b000;
    chk("wrap_zero", bus.wr_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
